ahb_mgr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single AHB subordinate port of the AHB-to-TL bridge among NM AHB managers.

---
 rtl/ahb_mgr_arbiter.sv | 98 +++++++++
 tb/tb_ahb_mgr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_mgr_arbiter.sv
// Round-robin AHB manager arbiter: one-hot grant, address/data owner pipeline, HLOCK, tenure cap.
// Grant one cycle after request; hready_i=0 stalls every register (no internal buffering).
module ahb_mgr_arbiter #(
  parameter int NM          = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int MAX_TENURE  = 16,
  localparam int MIDW       = $clog2(NM)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NM-1:0]   hbusreq_i,
  input  logic [NM-1:0]   hlock_i,
  input  logic [1:0]      htrans_i,
  input  logic            hready_i,
  output logic [NM-1:0]   hgrant_o,
  output logic [MIDW-1:0] hmaster_o,
  output logic [MIDW-1:0] hmaster_d_o,
  output logic            hmastlock_o
);

  localparam int TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [NM-1:0]   r_grant;
  logic [MIDW-1:0] r_owner;
  logic [MIDW-1:0] r_master;
  logic [MIDW-1:0] r_master_d;
  logic            r_mastlock;
  logic [TW-1:0]   r_tenure;

  logic            w_owner_req;
  logic            w_owner_lock;
  logic            w_others_req;
  logic            w_boundary;
  logic            w_expire;
  logic            w_rearb;
  logic            w_found;
  logic [MIDW-1:0] w_winner;
  logic            w_clear_tenure;
  logic            w_active_beat;

  assign w_owner_req   = hbusreq_i[r_owner];
  assign w_owner_lock  = hlock_i[r_owner];
  assign w_others_req  = |(hbusreq_i & ~r_grant);
  assign w_boundary    = (htrans_i == HTRANS_IDLE) || (htrans_i == HTRANS_NONSEQ);
  assign w_active_beat = htrans_i[1];

  // Tenure expiry only takes effect at a burst boundary so a burst is never split.
  assign w_expire = (MAX_TENURE != 0) && (r_tenure == TW'(MAX_TENURE)) && w_others_req && w_boundary;
  assign w_rearb  = hready_i && !w_owner_lock && (!w_owner_req || w_expire);

  // Scan starts just after the current owner; the owner itself is considered last.
  always_comb begin
    w_winner = MIDW'(DEFAULT_MGR);
    w_found  = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      int idx;
      idx = (int'(r_owner) + k) % NM;
      if (!w_found && hbusreq_i[idx]) begin
        w_found  = 1'b1;
        w_winner = idx[MIDW-1:0];
      end
    end
  end

  assign w_clear_tenure = w_rearb && ((w_winner != r_owner) || w_expire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant    <= NM'(1) << DEFAULT_MGR;
      r_owner    <= MIDW'(DEFAULT_MGR);
      r_master   <= MIDW'(DEFAULT_MGR);
      r_master_d <= MIDW'(DEFAULT_MGR);
      r_mastlock <= 1'b0;
      r_tenure   <= '0;
    end else if (hready_i) begin
      r_master_d <= r_master;
      r_master   <= r_owner;
      r_mastlock <= w_owner_lock;
      if (w_rearb) begin
        r_grant <= NM'(1) << w_winner;
        r_owner <= w_winner;
      end
      if (w_clear_tenure) begin
        r_tenure <= '0;
      end else if ((MAX_TENURE != 0) && w_active_beat && (r_tenure != TW'(MAX_TENURE))) begin
        r_tenure <= r_tenure + TW'(1);
      end
    end
  end

  assign hgrant_o    = r_grant;
  assign hmaster_o   = r_master;
  assign hmaster_d_o = r_master_d;
  assign hmastlock_o = r_mastlock;

endmodule

// File: tb/tb_ahb_mgr_arbiter.sv
// Directed bench for ahb_mgr_arbiter (NM=4, MAX_TENURE=4, DEFAULT_MGR=0).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ahb_mgr_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] hbusreq_i;
  logic [3:0] hlock_i;
  logic [1:0] htrans_i;
  logic       hready_i;
  logic [3:0] hgrant_o;
  logic [1:0] hmaster_o;
  logic [1:0] hmaster_d_o;
  logic       hmastlock_o;

  int errors = 0;
  int checks = 0;

  ahb_mgr_arbiter #(
    .NM(4),
    .DEFAULT_MGR(0),
    .MAX_TENURE(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .hbusreq_i(hbusreq_i),
    .hlock_i(hlock_i),
    .htrans_i(htrans_i),
    .hready_i(hready_i),
    .hgrant_o(hgrant_o),
    .hmaster_o(hmaster_o),
    .hmaster_d_o(hmaster_d_o),
    .hmastlock_o(hmastlock_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    hbusreq_i = 4'b0000;
    hlock_i   = 4'b0000;
    htrans_i  = IDLE;
    hready_i  = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    int cur;

    // 1: reset and parking
    do_reset();
    chk("rst_grant", 32'(hgrant_o), 32'h1);
    chk("rst_hmaster", 32'(hmaster_o), 32'h0);
    chk("rst_hmaster_d", 32'(hmaster_d_o), 32'h0);
    chk("rst_mastlock", 32'(hmastlock_o), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("park_grant", 32'(hgrant_o), 32'h1);
    end
    chk("park_hmaster", 32'(hmaster_o), 32'h0);

    // 2: request 1 and 2, owner idle -> mgr1 wins, then mgr2
    hbusreq_i = 4'b0110;
    tick();
    chk("t2_grant1", 32'(hgrant_o), 32'h2);
    chk("t2_hmaster_lag", 32'(hmaster_o), 32'h0);
    tick();
    chk("t2_hmaster1", 32'(hmaster_o), 32'h1);
    chk("t2_hmaster_d0", 32'(hmaster_d_o), 32'h0);
    tick();
    chk("t2_hmaster_d1", 32'(hmaster_d_o), 32'h1);
    hbusreq_i = 4'b0100;
    tick();
    chk("t2_grant2", 32'(hgrant_o), 32'h4);

    // 3: all request, NONSEQ every cycle -> rotation every 5 beats
    do_reset();
    hbusreq_i = 4'b1111;
    htrans_i  = NONSEQ;
    cur = 0;
    for (int r = 0; r < 4; r++) begin
      exp_g = 4'b0001 << cur;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("t3_hold", 32'(hgrant_o), 32'(exp_g));
      end
      tick();
      cur = (cur + 1) % 4;
      exp_g = 4'b0001 << cur;
      chk("t3_rotate", 32'(hgrant_o), 32'(exp_g));
    end

    // 4: locked owner mgr2 keeps the bus while mgr0 waits
    do_reset();
    hbusreq_i = 4'b0100;
    tick();
    chk("t4_grant2", 32'(hgrant_o), 32'h4);
    hbusreq_i = 4'b0101;
    hlock_i   = 4'b0100;
    htrans_i  = NONSEQ;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("t4_locked_hold", 32'(hgrant_o), 32'h4);
    end
    chk("t4_mastlock", 32'(hmastlock_o), 32'h1);
    chk("t4_hmaster2", 32'(hmaster_o), 32'h2);
    hlock_i = 4'b0000;
    tick();
    chk("t4_unlock_grant0", 32'(hgrant_o), 32'h1);
    chk("t4_mastlock_drop", 32'(hmastlock_o), 32'h0);

    // 5: wait states freeze grant and owner pipeline
    do_reset();
    hbusreq_i = 4'b0010;
    tick();
    chk("t5_grant1", 32'(hgrant_o), 32'h2);
    chk("t5_hmaster0", 32'(hmaster_o), 32'h0);
    hready_i  = 1'b0;
    hbusreq_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_grant", 32'(hgrant_o), 32'h2);
      chk("t5_stall_hmaster", 32'(hmaster_o), 32'h0);
      chk("t5_stall_hmaster_d", 32'(hmaster_d_o), 32'h0);
    end
    hready_i = 1'b1;
    tick();
    chk("t5_resume_hmaster", 32'(hmaster_o), 32'h1);
    chk("t5_resume_hmaster_d", 32'(hmaster_d_o), 32'h0);
    chk("t5_resume_grant", 32'(hgrant_o), 32'h4);

    // 6: tenure expiry waits for a burst boundary, then reset mid-burst
    do_reset();
    hbusreq_i = 4'b0011;
    htrans_i  = NONSEQ;
    tick();
    htrans_i = SEQ;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_seq_hold", 32'(hgrant_o), 32'h1);
    end
    htrans_i = NONSEQ;
    tick();
    chk("t6_boundary_grant1", 32'(hgrant_o), 32'h2);
    htrans_i = SEQ;
    hlock_i  = 4'b0010;
    tick();
    tick();
    chk("t6_pre_rst_hmaster", 32'(hmaster_o), 32'h1);
    chk("t6_pre_rst_mastlock", 32'(hmastlock_o), 32'h1);
    rst_i = 1'b1;
    tick();
    chk("t6_rst_grant", 32'(hgrant_o), 32'h1);
    chk("t6_rst_hmaster", 32'(hmaster_o), 32'h0);
    chk("t6_rst_hmaster_d", 32'(hmaster_d_o), 32'h0);
    chk("t6_rst_mastlock", 32'(hmastlock_o), 32'h0);
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
